display_mode_scheduler: RTL and testbench

- Sequences what the 4-digit seven-segment driver shows on the digital calendar.
- Auto-rotates between time (HH MM), date (DD MM) and year (YYYY) views; a pushbutton advances the view manually.
- Forces the time view and blinks the field being edited while time-set is active.
- Outputs registered BCD digits plus a per-digit blank mask to the display driver.

---
 rtl/display_mode_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_display_mode_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_mode_scheduler.sv
// View sequencer for the 4-digit calendar display: rotates TIME/DATE/YEAR views,
// handles manual stepping and time-set blinking, and registers the digit/blank outputs.
module display_mode_scheduler #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned TIME_SECS = 8,
    parameter int unsigned DATE_SECS = 3,
    parameter int unsigned YEAR_SECS = 3,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        btn_hold,
    input  logic        set_active,
    input  logic        set_field,
    input  logic [2:0]  hrs_tens,
    input  logic [3:0]  hrs_ones,
    input  logic [2:0]  mins_tens,
    input  logic [3:0]  mins_ones,
    input  logic [1:0]  day_tens,
    input  logic [3:0]  day_ones,
    input  logic        mon_tens,
    input  logic [3:0]  mon_ones,
    input  logic [15:0] year_bcd,
    output logic [3:0]  dig3,
    output logic [3:0]  dig2,
    output logic [3:0]  dig1,
    output logic [3:0]  dig0,
    output logic [3:0]  blank,
    output logic [1:0]  mode
);

    localparam logic [1:0] StTime = 2'b00;
    localparam logic [1:0] StDate = 2'b01;
    localparam logic [1:0] StYear = 2'b10;
    localparam logic [1:0] StBad  = 2'b11;

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam int unsigned MAX_TD   = (TIME_SECS > DATE_SECS) ? TIME_SECS : DATE_SECS;
    localparam int unsigned MAX_SECS = (MAX_TD > YEAR_SECS) ? MAX_TD : YEAR_SECS;
    localparam int unsigned DW       = (MAX_SECS > 1) ? $clog2(MAX_SECS) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [DW-1:0] TIME_LAST  = DW'(TIME_SECS - 1);
    localparam logic [DW-1:0] DATE_LAST  = DW'(DATE_SECS - 1);
    localparam logic [DW-1:0] YEAR_LAST  = DW'(YEAR_SECS - 1);

    // Button synchronizer, delay flop and set_active edge detector
    logic btn_meta_q;
    logic btn_sync_q;
    logic btn_dly_q;
    logic set_dly_q;
    logic next_pulse;
    logic set_rise;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_dly_q  <= 1'b0;
            set_dly_q  <= 1'b0;
        end else begin
            btn_meta_q <= btn_next;
            btn_sync_q <= btn_meta_q;
            btn_dly_q  <= btn_sync_q;
            set_dly_q  <= set_active;
        end
    end

    assign next_pulse = btn_sync_q & ~btn_dly_q;
    assign set_rise   = set_active & ~set_dly_q;

    // Free-running one-second tick
    logic [TW-1:0] tick_cnt_q;
    logic          sec_tick;

    assign sec_tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (sec_tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Blink timebase, restarted on entry to set mode so the field shows first
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;
    logic          blink_wrap;

    assign blink_wrap = (blink_cnt_q == BLINK_LAST);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (set_rise) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 1'b1;
        end
    end

    // View state machine with per-view dwell counter
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [1:0]    state_adv;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    logic [DW-1:0] dwell_last;

    always_comb begin
        state_adv  = StTime;
        dwell_last = TIME_LAST;
        case (state_q)
            StTime: begin
                state_adv  = StDate;
                dwell_last = TIME_LAST;
            end
            StDate: begin
                state_adv  = StYear;
                dwell_last = DATE_LAST;
            end
            StYear: begin
                state_adv  = StTime;
                dwell_last = YEAR_LAST;
            end
            default: begin
                state_adv  = StTime;
                dwell_last = TIME_LAST;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        if (set_active) begin
            state_d = StTime;
            dwell_d = '0;
        end else if (state_q == StBad) begin
            state_d = StTime;
            dwell_d = '0;
        end else if (next_pulse) begin
            // Also covers a coincident auto-advance: still a single step
            state_d = state_adv;
            dwell_d = '0;
        end else if (!btn_hold && sec_tick) begin
            if (dwell_q == dwell_last) begin
                state_d = state_adv;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= StTime;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    assign mode = state_q;

    // Registered digit and blank outputs
    logic [3:0] dig3_d;
    logic [3:0] dig2_d;
    logic [3:0] dig1_d;
    logic [3:0] dig0_d;
    logic [3:0] blank_d;

    always_comb begin
        dig3_d = {1'b0, hrs_tens};
        dig2_d = hrs_ones;
        dig1_d = {1'b0, mins_tens};
        dig0_d = mins_ones;
        case (state_q)
            StDate: begin
                dig3_d = {2'b00, day_tens};
                dig2_d = day_ones;
                dig1_d = {3'b000, mon_tens};
                dig0_d = mon_ones;
            end
            StYear: begin
                dig3_d = year_bcd[15:12];
                dig2_d = year_bcd[11:8];
                dig1_d = year_bcd[7:4];
                dig0_d = year_bcd[3:0];
            end
            default: begin
                dig3_d = {1'b0, hrs_tens};
                dig2_d = hrs_ones;
                dig1_d = {1'b0, mins_tens};
                dig0_d = mins_ones;
            end
        endcase
    end

    always_comb begin
        blank_d = 4'b0000;
        if (set_active) begin
            if (blink_phase_q) begin
                blank_d = set_field ? 4'b0011 : 4'b1100;
            end
        end else if (state_q == StTime && hrs_tens == 3'd0) begin
            blank_d = 4'b1000;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            dig3  <= 4'd0;
            dig2  <= 4'd0;
            dig1  <= 4'd0;
            dig0  <= 4'd0;
            blank <= 4'b1111;
        end else begin
            dig3  <= dig3_d;
            dig2  <= dig2_d;
            dig1  <= dig1_d;
            dig0  <= dig0_d;
            blank <= blank_d;
        end
    end

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Directed bench for display_mode_scheduler with short tick/dwell/blink periods.
module tb_display_mode_scheduler;

    logic        clk_100MHz;
    logic        reset;
    logic        btn_next;
    logic        btn_hold;
    logic        set_active;
    logic        set_field;
    logic [2:0]  hrs_tens;
    logic [3:0]  hrs_ones;
    logic [2:0]  mins_tens;
    logic [3:0]  mins_ones;
    logic [1:0]  day_tens;
    logic [3:0]  day_ones;
    logic        mon_tens;
    logic [3:0]  mon_ones;
    logic [15:0] year_bcd;
    logic [3:0]  dig3;
    logic [3:0]  dig2;
    logic [3:0]  dig1;
    logic [3:0]  dig0;
    logic [3:0]  blank;
    logic [1:0]  mode;

    int checks;
    int errors;
    int ecnt;
    int base;

    display_mode_scheduler #(
        .TICK_DIV  (4),
        .TIME_SECS (3),
        .DATE_SECS (2),
        .YEAR_SECS (2),
        .BLINK_DIV (5)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_next   (btn_next),
        .btn_hold   (btn_hold),
        .set_active (set_active),
        .set_field  (set_field),
        .hrs_tens   (hrs_tens),
        .hrs_ones   (hrs_ones),
        .mins_tens  (mins_tens),
        .mins_ones  (mins_ones),
        .day_tens   (day_tens),
        .day_ones   (day_ones),
        .mon_tens   (mon_tens),
        .mon_ones   (mon_ones),
        .year_bcd   (year_bcd),
        .dig3       (dig3),
        .dig2       (dig2),
        .dig1       (dig1),
        .dig0       (dig0),
        .blank      (blank),
        .mode       (mode)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    // Edges since reset release; tick edges are those with ecnt % 4 == 0
    always @(posedge clk_100MHz) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic wait_to(input int k);
        while (ecnt < k) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_next = 0; btn_hold = 0; set_active = 0; set_field = 0;
        hrs_tens = 0; hrs_ones = 0; mins_tens = 0; mins_ones = 0;
        day_tens = 0; day_ones = 0; mon_tens = 0; mon_ones = 0; year_bcd = 0;
        #12;
        checks++;
        if (blank !== 4'b1111) begin
            errors++; $display("FAIL reset_blank: got %b expected 1111", blank);
        end
        checks++;
        if (mode !== 2'b00) begin
            errors++; $display("FAIL reset_mode: got %b expected 00", mode);
        end
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'h0000) begin
            errors++; $display("FAIL reset_digits: got %h expected 0000", {dig3, dig2, dig1, dig0});
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_auto_rotate();
        wait_to(1);
        checks++;
        if (blank !== 4'b1000) begin
            errors++; $display("FAIL idle_blank: got %b expected 1000", blank);
        end
        wait_to(11);
        checks++;
        if (mode !== 2'b00) begin
            errors++; $display("FAIL rot_time_end: got %b expected 00", mode);
        end
        wait_to(12);
        checks++;
        if (mode !== 2'b01) begin
            errors++; $display("FAIL rot_to_date: got %b expected 01", mode);
        end
        wait_to(19);
        checks++;
        if (mode !== 2'b01) begin
            errors++; $display("FAIL rot_date_end: got %b expected 01", mode);
        end
        wait_to(20);
        checks++;
        if (mode !== 2'b10) begin
            errors++; $display("FAIL rot_to_year: got %b expected 10", mode);
        end
        wait_to(28);
        checks++;
        if (mode !== 2'b00) begin
            errors++; $display("FAIL rot_to_time: got %b expected 00", mode);
        end
    endtask

    task automatic test_digits();
        hrs_tens = 3'd0; hrs_ones = 4'd9; mins_tens = 3'd4; mins_ones = 4'd7;
        day_tens = 2'd2; day_ones = 4'd5; mon_tens = 1'b1; mon_ones = 4'd2;
        year_bcd = 16'h2024;
        wait_to(29);
        checks++;
        if ({dig3, dig2, dig1, dig0, blank} !== 20'h0947_8) begin
            errors++;
            $display("FAIL time_view: got %h/%b expected 0947/1000", {dig3, dig2, dig1, dig0}, blank);
        end
        wait_to(41);
        checks++;
        if ({mode, dig3, dig2, dig1, dig0, blank} !== {2'b01, 16'h2512, 4'b0000}) begin
            errors++;
            $display("FAIL date_view: got %b %h/%b expected 01 2512/0000",
                     mode, {dig3, dig2, dig1, dig0}, blank);
        end
        wait_to(49);
        checks++;
        if ({mode, dig3, dig2, dig1, dig0, blank} !== {2'b10, 16'h2024, 4'b0000}) begin
            errors++;
            $display("FAIL year_view: got %b %h/%b expected 10 2024/0000",
                     mode, {dig3, dig2, dig1, dig0}, blank);
        end
    endtask

    task automatic test_next_button();
        wait_to(61);
        btn_next = 1'b1;
        wait_to(63);
        checks++;
        if (mode !== 2'b00) begin
            errors++; $display("FAIL next_latency: got %b expected 00", mode);
        end
        wait_to(64);
        checks++;
        if (mode !== 2'b01) begin
            errors++; $display("FAIL next_step: got %b expected 01", mode);
        end
        wait_to(66);
        btn_next = 1'b0;
        wait_to(71);
        checks++;
        if (mode !== 2'b01) begin
            errors++; $display("FAIL next_dwell_restart: got %b expected 01", mode);
        end
        wait_to(72);
        checks++;
        if (mode !== 2'b10) begin
            errors++; $display("FAIL next_date_full: got %b expected 10", mode);
        end
    endtask

    task automatic test_hold();
        logic [1:0] seq [3];
        logic [1:0] prev;
        int         moved;
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10;
        btn_hold = 1'b1;
        moved = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (mode !== 2'b10) moved++;
        end
        checks++;
        if (moved !== 0) begin
            errors++; $display("FAIL hold_freeze: got %0d changed cycles expected 0", moved);
        end
        prev = 2'b10;
        for (int p = 0; p < 3; p++) begin
            btn_next = 1'b1;
            step();
            step();
            checks++;
            if (mode !== prev) begin
                errors++; $display("FAIL hold_next_early%0d: got %b expected %b", p, mode, prev);
            end
            step();
            checks++;
            if (mode !== seq[p]) begin
                errors++; $display("FAIL hold_next_step%0d: got %b expected %b", p, mode, seq[p]);
            end
            prev = seq[p];
            btn_next = 1'b0;
            step(); step(); step();
        end
    endtask

    task automatic test_set_mode();
        logic [1:0] exp_lo;
        set_active = 1'b1;
        set_field  = 1'b1;
        btn_hold   = 1'b0;
        step();
        checks++;
        if (mode !== 2'b00) begin
            errors++; $display("FAIL set_force_time: got %b expected 00", mode);
        end
        for (int i = 1; i <= 15; i++) begin
            step();
            exp_lo = (i <= 5 || i >= 11) ? 2'b00 : 2'b11;
            checks++;
            if (blank !== {2'b00, exp_lo}) begin
                errors++; $display("FAIL set_blink%0d: got %b expected 00%b", i, blank, exp_lo);
            end
            checks++;
            if (mode !== 2'b00) begin
                errors++; $display("FAIL set_ignore_next%0d: got %b expected 00", i, mode);
            end
            if (i == 1) btn_next = 1'b1;
            if (i == 6) btn_next = 1'b0;
        end
        set_field = 1'b0;
        step();
        checks++;
        if (blank !== 4'b1100) begin
            errors++; $display("FAIL set_field_hours: got %b expected 1100", blank);
        end
        while (ecnt % 4 != 0) step();
        set_active = 1'b0;
        base = ecnt;
        wait_to(base + 1);
        checks++;
        if (blank !== 4'b1000) begin
            errors++; $display("FAIL set_exit_blank: got %b expected 1000", blank);
        end
        wait_to(base + 11);
        checks++;
        if (mode !== 2'b00) begin
            errors++; $display("FAIL set_exit_dwell: got %b expected 00", mode);
        end
        wait_to(base + 12);
        checks++;
        if (mode !== 2'b01) begin
            errors++; $display("FAIL set_exit_advance: got %b expected 01", mode);
        end
    endtask

    task automatic test_back_to_back();
        wait_to(base + 25);
        btn_next = 1'b1;
        wait_to(base + 27);
        checks++;
        if (mode !== 2'b10) begin
            errors++; $display("FAIL b2b_pre: got %b expected 10", mode);
        end
        wait_to(base + 28);
        checks++;
        if (mode !== 2'b00) begin
            errors++; $display("FAIL b2b_single_step: got %b expected 00", mode);
        end
        btn_next = 1'b0;
    endtask

    task automatic test_async_reset();
        wait_to(base + 42);
        checks++;
        if (mode !== 2'b01) begin
            errors++; $display("FAIL areset_pre: got %b expected 01", mode);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (mode !== 2'b00) begin
            errors++; $display("FAIL areset_mode: got %b expected 00", mode);
        end
        checks++;
        if (blank !== 4'b1111) begin
            errors++; $display("FAIL areset_blank: got %b expected 1111", blank);
        end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        base   = 0;
        test_reset();
        test_auto_rotate();
        test_digits();
        test_next_button();
        test_hold();
        test_set_mode();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
